// File: rtl/friscv_cache_nway_blocks.sv
// Set-associative line store: NB_WAYS x CACHE_DEPTH lines, round-robin victims, sequenced flush.
// state | meaning -- FLUSH: clears valid of set fc in every way, one set per cycle; IDLE: serves fills and lookups
module friscv_cache_nway_blocks #(
  parameter int ILEN          = 32,
  parameter int ADDR_W        = 32,
  parameter int CACHE_BLOCK_W = 128,
  parameter int CACHE_DEPTH   = 512,
  parameter int NB_WAYS       = 2
) (
  input  logic                       aclk,
  input  logic                       srst,
  input  logic                       flush,
  output logic                       ready,
  input  logic                       p1_wen,
  input  logic [ADDR_W-1:0]          p1_waddr,
  input  logic [CACHE_BLOCK_W-1:0]   p1_wdata,
  input  logic [CACHE_BLOCK_W/8-1:0] p1_wstrb,
  input  logic                       p1_ren,
  input  logic [ADDR_W-1:0]          p1_raddr,
  output logic [ILEN-1:0]            p1_rdata,
  output logic                       p1_hit,
  output logic                       p1_miss,
  input  logic                       p2_wen,
  input  logic [ADDR_W-1:0]          p2_waddr,
  input  logic [CACHE_BLOCK_W-1:0]   p2_wdata,
  input  logic [CACHE_BLOCK_W/8-1:0] p2_wstrb,
  input  logic                       p2_ren,
  input  logic [ADDR_W-1:0]          p2_raddr,
  output logic [ILEN-1:0]            p2_rdata,
  output logic                       p2_hit,
  output logic                       p2_miss
);

  localparam int NB_WORDS = CACHE_BLOCK_W / ILEN;
  localparam int OFFSET_W = $clog2(NB_WORDS);
  localparam int OFF_W    = (OFFSET_W > 0) ? OFFSET_W : 1;
  localparam int INDEX_W  = $clog2(CACHE_DEPTH);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int WAY_W    = (NB_WAYS > 1) ? $clog2(NB_WAYS) : 1;
  localparam int STRB_W   = CACHE_BLOCK_W / 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]               state;
  logic [INDEX_W-1:0]       fc;
  logic [CACHE_BLOCK_W-1:0] data_mem  [NB_WAYS][CACHE_DEPTH];
  logic [TAG_W-1:0]         tag_mem   [NB_WAYS][CACHE_DEPTH];
  logic                     valid_mem [NB_WAYS][CACHE_DEPTH];
  logic [WAY_W-1:0]         vptr      [CACHE_DEPTH];

  logic [ADDR_W-1:0]        raddr, waddr;
  logic [CACHE_BLOCK_W-1:0] wdata;
  logic [STRB_W-1:0]        wstrb;
  logic [INDEX_W-1:0]       ridx, widx;
  logic [TAG_W-1:0]         rtag, wtag;
  logic [OFF_W-1:0]         roff;
  logic [WAY_W-1:0]         victim, victim_next, lk_way;
  logic                     lk_hit;
  logic [ILEN-1:0]          lk_word;
  logic                     idle_op, wr_en;
  logic                     unused_bits;

  // Port 1 has priority on both the fill and the lookup path
  assign raddr = p1_ren ? p1_raddr : p2_raddr;
  assign waddr = p1_wen ? p1_waddr : p2_waddr;
  assign wdata = p1_wen ? p1_wdata : p2_wdata;
  assign wstrb = p1_wen ? p1_wstrb : p2_wstrb;

  assign ridx = raddr[2+OFFSET_W +: INDEX_W];
  assign widx = waddr[2+OFFSET_W +: INDEX_W];
  assign rtag = raddr[ADDR_W-1 -: TAG_W];
  assign wtag = waddr[ADDR_W-1 -: TAG_W];
  assign roff = OFF_W'(raddr[ADDR_W-1:2]) & OFF_W'(NB_WORDS - 1);
  assign unused_bits = ^{raddr[1:0], waddr[2+OFFSET_W-1:0]};

  assign ready   = (state == ST_IDLE);
  assign idle_op = (state == ST_IDLE) && !flush;
  assign wr_en   = idle_op && (p1_wen || p2_wen);

  assign victim      = vptr[widx];
  assign victim_next = (victim == WAY_W'(NB_WAYS - 1)) ? '0 : victim + WAY_W'(1);

  // Descending scan so the lowest matching way wins
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = NB_WAYS - 1; w >= 0; w--) begin
      if (valid_mem[w][ridx] && (tag_mem[w][ridx] == rtag)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  assign lk_word = data_mem[lk_way][ridx][roff*ILEN +: ILEN];

  always_ff @(posedge aclk) begin
    if (!srst) begin
      if (state == ST_FLUSH) begin
        for (int w = 0; w < NB_WAYS; w++) valid_mem[w][fc] <= 1'b0;
      end else if (wr_en) begin
        valid_mem[victim][widx] <= 1'b1;
        tag_mem[victim][widx]   <= wtag;
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb[b]) data_mem[victim][widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state    <= ST_FLUSH;
      fc       <= '0;
      p1_hit   <= 1'b0;
      p1_miss  <= 1'b0;
      p1_rdata <= '0;
      p2_hit   <= 1'b0;
      p2_miss  <= 1'b0;
      p2_rdata <= '0;
      for (int i = 0; i < CACHE_DEPTH; i++) vptr[i] <= '0;
    end else if (state == ST_FLUSH) begin
      fc <= fc + INDEX_W'(1);
      if (fc == INDEX_W'(CACHE_DEPTH - 1)) state <= ST_IDLE;
    end else begin
      p1_hit  <= 1'b0;
      p1_miss <= 1'b0;
      p2_hit  <= 1'b0;
      p2_miss <= 1'b0;
      if (flush) begin
        state <= ST_FLUSH;
        fc    <= '0;
      end else begin
        if (p1_ren) begin
          p1_hit   <= lk_hit;
          p1_miss  <= !lk_hit;
          p1_rdata <= lk_word;
        end else if (p2_ren) begin
          p2_hit   <= lk_hit;
          p2_miss  <= !lk_hit;
          p2_rdata <= lk_word;
        end
        if (p1_wen || p2_wen) vptr[widx] <= victim_next;
      end
    end
  end

endmodule

// File: tb/tb_friscv_cache_nway_blocks.sv
// Scoreboard bench: a line-address/FIFO-eviction model predicts lookups; a monitor compares each cycle.
module tb_friscv_cache_nway_blocks;
  localparam int DEPTH = 512;
  localparam int WAYS  = 2;

  logic         aclk = 1'b0;
  logic         srst, flush, ready;
  logic         p1_wen, p2_wen, p1_ren, p2_ren;
  logic [31:0]  p1_waddr, p2_waddr, p1_raddr, p2_raddr;
  logic [127:0] p1_wdata, p2_wdata;
  logic [15:0]  p1_wstrb, p2_wstrb;
  logic [31:0]  p1_rdata, p2_rdata;
  logic         p1_hit, p1_miss, p2_hit, p2_miss;

  always #5 aclk = ~aclk;

  friscv_cache_nway_blocks dut (
    .aclk(aclk), .srst(srst), .flush(flush), .ready(ready),
    .p1_wen(p1_wen), .p1_waddr(p1_waddr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p1_ren(p1_ren), .p1_raddr(p1_raddr), .p1_rdata(p1_rdata), .p1_hit(p1_hit), .p1_miss(p1_miss),
    .p2_wen(p2_wen), .p2_waddr(p2_waddr), .p2_wdata(p2_wdata), .p2_wstrb(p2_wstrb),
    .p2_ren(p2_ren), .p2_raddr(p2_raddr), .p2_rdata(p2_rdata), .p2_hit(p2_hit), .p2_miss(p2_miss)
  );

  typedef struct {
    int          due;
    bit          p1_hit, p1_miss, p2_hit, p2_miss;
    bit          p1_dchk, p2_dchk;
    logic [31:0] p1_data, p2_data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  // Model: resident lines per set in fill order (oldest is next victim), payload by line number
  logic [127:0] mdata [int];
  int           res_q [DEPTH][$];
  int           m_busy = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit resident(input int line);
    int s = line % DEPTH;
    for (int i = 0; i < res_q[s].size(); i++) if (res_q[s][i] == line) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] make_addr(input int tag, input int set, input int off);
    return (32'(tag) << 13) | (32'(set) << 4) | (32'(off) << 2);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) res_q[i].delete();
    mdata.delete();
  endtask

  task automatic model_fill(input logic [31:0] a, input logic [127:0] d, input logic [15:0] st);
    int line = int'(a >> 4);
    int s = line % DEPTH;
    int ev;
    logic [127:0] v = '0;
    if (res_q[s].size() == WAYS) begin
      ev = res_q[s].pop_front();
      v = mdata[ev];
      mdata.delete(ev);
    end
    for (int b = 0; b < 16; b++) if (st[b]) v[b*8 +: 8] = d[b*8 +: 8];
    mdata[line] = v;
    res_q[s].push_back(line);
  endtask

  task automatic lookup(input logic [31:0] a, output bit h, output logic [31:0] w);
    int line = int'(a >> 4);
    logic [127:0] d;
    h = resident(line);
    w = '0;
    if (h) begin
      d = mdata[line] >> (32 * int'(a[3:2]));
      w = d[31:0];
    end
  endtask

  task automatic idle_inputs();
    srst = 1'b0; flush = 1'b0;
    p1_wen = 1'b0; p2_wen = 1'b0; p1_ren = 1'b0; p2_ren = 1'b0;
    p1_waddr = '0; p2_waddr = '0; p1_raddr = '0; p2_raddr = '0;
    p1_wdata = '0; p2_wdata = '0; p1_wstrb = '0; p2_wstrb = '0;
  endtask

  // Predict the effect of the coming edge, then advance one cycle
  task automatic step();
    bit idle = (m_busy == 0);
    bit h;
    logic [31:0] w;
    exp_t e;
    if (srst) begin
      m_busy = DEPTH;
      clear_model();
    end else if (!idle) begin
      m_busy--;
    end else if (flush) begin
      m_busy = DEPTH;
      clear_model();
    end else begin
      if (p1_ren || p2_ren) begin
        lookup(p1_ren ? p1_raddr : p2_raddr, h, w);
        e.due = cyc + 1;
        e.p1_hit = p1_ren && h;   e.p1_miss = p1_ren && !h;
        e.p2_hit = !p1_ren && h;  e.p2_miss = !p1_ren && !h;
        e.p1_dchk = p1_ren && h;  e.p2_dchk = !p1_ren && h;
        e.p1_data = w;            e.p2_data = w;
        sb.push_back(e);
      end
      if (p1_wen) model_fill(p1_waddr, p1_wdata, p1_wstrb);
      else if (p2_wen) model_fill(p2_waddr, p2_wdata, p2_wstrb);
    end
    @(posedge aclk);
    #1;
    check("ready", ready, m_busy == 0);
  endtask

  task automatic monitor_cycle();
    exp_t e;
    e.due = 0;
    e.p1_hit = 0; e.p1_miss = 0; e.p2_hit = 0; e.p2_miss = 0;
    e.p1_dchk = 0; e.p2_dchk = 0; e.p1_data = '0; e.p2_data = '0;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      void'(sb.pop_front());
      check("stale_expectation", 1, 0);
    end
    if (sb.size() > 0 && sb[0].due == cyc) e = sb.pop_front();
    check("p1_hit_miss", {p1_hit, p1_miss}, {e.p1_hit, e.p1_miss});
    check("p2_hit_miss", {p2_hit, p2_miss}, {e.p2_hit, e.p2_miss});
    if (e.p1_dchk) check("p1_rdata", p1_rdata, e.p1_data);
    if (e.p2_dchk) check("p2_rdata", p2_rdata, e.p2_data);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 2000) begin
      p1_ren = 1'($urandom_range(0, 1));
      p1_raddr = make_addr(1, 'h100, 0);
      step();
      n++;
    end
    p1_ren = 1'b0;
    check(name, n, DEPTH);
  endtask

  task automatic fill(input bit p2, input logic [31:0] a, input logic [127:0] d, input logic [15:0] st);
    if (p2) begin p2_wen = 1'b1; p2_waddr = a; p2_wdata = d; p2_wstrb = st; end
    else begin p1_wen = 1'b1; p1_waddr = a; p1_wdata = d; p1_wstrb = st; end
    step();
    p1_wen = 1'b0; p2_wen = 1'b0;
  endtask

  task automatic rd(input bit en1, input logic [31:0] a1, input bit en2, input logic [31:0] a2);
    p1_ren = en1; p1_raddr = a1; p2_ren = en2; p2_raddr = a2;
    step();
    p1_ren = 1'b0; p2_ren = 1'b0;
  endtask

  function automatic logic [31:0] free_addr(input int set);
    int t;
    for (int k = 0; k < 64; k++) begin
      t = int'($urandom_range(1, 5));
      if (!resident(t * DEPTH + set)) return make_addr(t, set, 0);
    end
    for (int tt = 1; tt <= 5; tt++) if (!resident(tt * DEPTH + set)) return make_addr(tt, set, 0);
    return make_addr(6, set, 0);
  endfunction

  task automatic random_phase(input int n);
    int sets[3] = '{'h100, 'h005, 'h1FF};
    int s;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        s = sets[$urandom_range(0, 2)];
        p1_wen = 1'($urandom_range(0, 1));
        p2_wen = !p1_wen || ($urandom_range(0, 3) == 0);
        p1_waddr = free_addr(s);
        p2_waddr = free_addr(s);
        p1_wdata = {$urandom, $urandom, $urandom, $urandom};
        p2_wdata = {$urandom, $urandom, $urandom, $urandom};
        p1_wstrb = (res_q[s].size() == WAYS) ? 16'($urandom) : 16'hFFFF;
        p2_wstrb = 16'hFFFF;
      end
      p1_ren = 1'($urandom_range(0, 1));
      p2_ren = 1'($urandom_range(0, 1));
      p1_raddr = make_addr(int'($urandom_range(1, 5)), sets[$urandom_range(0, 2)], int'($urandom_range(0, 3)));
      p2_raddr = make_addr(int'($urandom_range(1, 5)), sets[$urandom_range(0, 2)], int'($urandom_range(0, 3)));
      step();
      idle_inputs();
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge aclk);
        if (mon_en) monitor_cycle();
      end
    join_none

    idle_inputs();
    srst = 1'b1;
    step();
    srst = 1'b0;
    mon_en = 1'b1;
    check("reset_p1_rdata", p1_rdata, 0);
    check("reset_p2_rdata", p2_rdata, 0);
    wait_ready("reset_ready_cycles");

    rd(1, 32'h0, 0, 32'h0);
    fill(0, 32'h1000, 128'h44443333_22221111_00000000_DEADBEEF, 16'hFFFF);
    rd(1, 32'h1008, 0, 32'h0);
    rd(0, 32'h0, 1, 32'h100C);
    rd(1, 32'h1000, 1, 32'h1004);
    fill(0, 32'h3000, 128'h33333333_33333333_33333333_33333333, 16'hFFFF);
    fill(1, 32'h5000, 128'h55555555_55555555_55555555_55555555, 16'hFFFF);
    rd(1, 32'h1000, 0, 32'h0);
    rd(1, 32'h3004, 0, 32'h0);
    rd(0, 32'h0, 1, 32'h5008);
    fill(0, 32'h7000, 128'h77777777_77777777_77777777_77777777, 16'h00F0);
    for (int o = 0; o < 4; o++) rd(1, 32'h7000 + 32'(o * 4), 0, 32'h0);
    rd(1, 32'h3000, 0, 32'h0);
    p2_wen = 1'b1; p2_waddr = 32'h9000; p2_wdata = 128'h9; p2_wstrb = 16'hFFFF;
    rd(1, 32'h9000, 0, 32'h0);
    p2_wen = 1'b0;
    rd(1, 32'h9000, 0, 32'h0);
    p1_wen = 1'b1; p1_waddr = 32'hB000; p1_wdata = 128'hB; p1_wstrb = 16'hFFFF;
    fill(1, 32'hD000, 128'hD, 16'hFFFF);
    rd(1, 32'hB000, 0, 32'h0);
    rd(0, 32'h0, 1, 32'hD000);

    random_phase(400);

    flush = 1'b1; p1_ren = 1'b1; p1_raddr = 32'hB000;
    step();
    idle_inputs();
    wait_ready("flush_ready_cycles");
    rd(1, 32'hB000, 0, 32'h0);
    rd(0, 32'h0, 1, 32'h9000);
    rd(1, 32'h7000, 0, 32'h0);

    random_phase(300);

    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (100) step();
    srst = 1'b1; flush = 1'b1;
    step();
    idle_inputs();
    wait_ready("srst_mid_flush_ready_cycles");

    random_phase(300);
    idle_inputs();
    step();
    step();
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/friscv_cache_nway_blocks.md
# friscv_cache_nway_blocks

Set-associative storage core for the instruction/data caches: NB_WAYS ways of CACHE_DEPTH sets, each set line holding CACHE_BLOCK_W payload bits plus a tag and a valid bit. It generalises the direct-mapped block store with configurable associativity, a per-set round-robin victim pointer and a sequenced flush engine that clears every valid bit. It sits between the cache fetcher/controller, which issues fills and lookups, and the RAM primitives. Two exclusive-access ports are supported, with port 1 having priority.

## Interface
- ILEN, 32: instruction/word width returned on a read
- ADDR_W, 32: byte address width
- CACHE_BLOCK_W, 128: line payload in bits; multiple of ILEN, power of 2
- CACHE_DEPTH, 512: number of sets; power of 2, ≥2
- NB_WAYS, 2: ways per set; power of 2, 1..8
- aclk  in  1  clock
- srst  in  1  synchronous active-high reset
- flush  in  1  pulse; invalidate the whole cache
- ready  out  1  1 when IDLE (reads/writes accepted)
- p1_wen / p2_wen  in  1  line fill request
- p1_waddr / p2_waddr  in  ADDR_W  fill byte address
- p1_wdata / p2_wdata  in  CACHE_BLOCK_W  fill payload
- p1_wstrb / p2_wstrb  in  CACHE_BLOCK_W/8  byte enables for the payload
- p1_ren / p2_ren  in  1  lookup request
- p1_raddr / p2_raddr  in  ADDR_W  lookup byte address
- p1_rdata / p2_rdata  out  ILEN  selected word
- p1_hit / p2_hit  out  1  lookup hit
- p1_miss / p2_miss  out  1  lookup miss

## Operation
- Address split: OFFSET_W=log2(CACHE_BLOCK_W/ILEN) at bit 2, INDEX_W=log2(CACHE_DEPTH) above it, and TAG_W=ADDR_W-INDEX_W-OFFSET_W-2 in the MSBs. WAY_W=max(1,log2(NB_WAYS)).
- Storage: one byte-enabled data RAM and one metadata RAM ({valid,tag}) per way, both with combinational read. Victim pointers are held in a CACHE_DEPTH×WAY_W flop array.
- FSM states:
  - FLUSH: flush counter fc walks from 0 to CACHE_DEPTH-1, one set per cycle, writing valid=0 in every way. At fc=CACHE_DEPTH-1 → IDLE.
  - IDLE: serves reads and writes; ready=1.
- Transitions:
  - srst → FLUSH, with fc=0 and all victim pointers cleared to 0.
  - flush in IDLE → FLUSH next cycle, fc=0. The flush takes priority over any wen/ren in the same cycle; those are ignored.
  - flush asserted while in FLUSH: ignored.
- While in FLUSH: wen and ren are ignored; hit, miss, rdata and victim pointers stay unchanged except where the rules above clear them.
- Write (IDLE):
  - If p1_wen is set, port 1 is written, otherwise port 2.
  - The victim way v=ptr[index] receives wdata under wstrb and metadata {1,tag}.
  - ptr[index] then increments modulo NB_WAYS.
  - A fill of a line that is already resident is illegal; the controller guarantees it never happens.
- Read (IDLE):
  - If p1_ren is set, port 1 is served; otherwise port 2 if p2_ren.
  - All ways at rindex are compared: hit = OR over ways of (valid && tag match), miss = !hit.
  - rdata = the matching way's word at that port's own offset. If more than one way matches, the lowest way wins.
  - On a miss, rdata is the way 0 word (don't care).
  - Port 1 and port 2 each use their own offset.
- When both ports read in the same cycle, port 1 is served and port 2's hit and miss are 0 for that cycle. The requester must retry.
- A port that is not served, or a cycle with no ren, drives hit=miss=0 on that port. rdata holds its last value.
- A read and a write to the same set in the same cycle: the read returns the pre-write contents.

## Timing
- Reset values: hit=0, miss=0, rdata=0 on both ports; ready=0.
- After srst deasserts, ready rises after exactly CACHE_DEPTH cycles (FLUSH occupies CACHE_DEPTH cycles).
- flush sampled in IDLE: ready=0 on the next cycle and for CACHE_DEPTH cycles.
- Read latency is 1 cycle: ren at edge N gives hit/miss/rdata valid after edge N+1, for one cycle only.
- A write takes effect at the sampling edge and is visible to a read issued on the next cycle.
- srst asserted mid-FLUSH restarts fc at 0. srst overrides flush.

## Test plan
Defaults throughout (2 ways, 512 sets: index=addr[12:4], tag=addr[31:13]).
- Pulse srst for 1 cycle → ready=0 for 512 cycles, then 1. p1 read 0x0 → miss=1, hit=0.
- Fill p1 0x1000 with data 0x44443333_22221111_00000000_DEADBEEF and wstrb 0xFFFF. Then p1 read 0x1008 → hit=1, rdata=0x22221111, one cycle later.
- Fill 0x1000, 0x3000 and 0x5000 (all index 0x100) → 0x1000 misses, 0x3000 and 0x5000 hit. A fourth fill of 0x7000 evicts 0x3000.
- p2-only read of 0x100C after the 0x1000 fill → p2_hit=1, p2_rdata=0x44443333. Simultaneous p1 read 0x1000 and p2 read 0x1004 → p1_hit=1, p2_hit=p2_miss=0.
- Read and fill of 0x9000 at index 0x100 in the same cycle → read misses. The same read one cycle later hits.
- flush pulse after fills → ready low for 512 cycles and ren ignored, then all prior addresses miss. srst at flush cycle 100 → ready low for 512 more cycles.
